// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and the constant log2 helper used for pointer widths.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Smallest n with 2**n >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error flags and an
// optional first-word-fall-through read mode.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 16,
    parameter int  AF_THRESH  = DEPTH - 2,
    parameter int  AE_THRESH  = 2,
    parameter int  FWFT       = FIFO_MODE_STD,
    localparam int PTR_WIDTH  = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [PTR_WIDTH:0]    wr_ptr;
    logic [PTR_WIDTH:0]    rd_ptr;
    logic [PTR_WIDTH:0]    rd_ptr_inc;
    logic [PTR_WIDTH-1:0]  mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  rd_ok;
    logic                  wr_ok;

    // Handshake: a request is accepted on the rising edge where it is high and the FIFO can
    // take it. A read needs a held word; a write needs a free slot, or a read accepted in the
    // same cycle (at full both complete). Refused requests set the matching sticky error.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    assign rd_ptr_inc = rd_ptr + (PTR_WIDTH + 1)'(1);

    // Standard mode reads the head on the pop edge; FWFT pre-fetches the word behind the head.
    assign mem_raddr = (FWFT == FIFO_MODE_FWFT) ? rd_ptr_inc[PTR_WIDTH-1:0]
                                                : rd_ptr[PTR_WIDTH-1:0];

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok & rst_n),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        data_next = data_out;
        if (FWFT == FIFO_MODE_FWFT) begin
            // The new head comes from data_in whenever it is the word being written this edge.
            if (count_next != '0) begin
                if (empty) begin
                    data_next = data_in;
                end else if (rd_ok) begin
                    data_next = (rd_ptr_inc == wr_ptr) ? data_in : mem_rdata;
                end
            end
        end else if (rd_ok) begin
            data_next = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (PTR_WIDTH + 1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_inc;
            end
            count        <= count_next;
            data_out     <= data_next;
            full         <= (count_next == CNT_FULL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_LVL);
            almost_empty <= (count_next <= AE_LVL);
            // A new error in the same cycle as clr_err leaves the flag set.
            overflow     <= (overflow & ~clr_err) | (w_en & ~wr_ok);
            underflow    <= (underflow & ~clr_err) | (r_en & ~rd_ok);
        end
    end

endmodule
